// File: rtl/id_alu_pipe_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : id_alu_pipe_stage_pkg                                            |
// | Purpose : Shared constants and types for the handshaked pipeline stage     |
// |           (payload width, reset payload, skid-mode control states).        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package id_alu_pipe_stage_pkg;

  // Width of the packed ID bundle carried as one payload.
  localparam int PIPE_STAGE_W = 177;

  // Payload shown on out_data while the stage holds nothing (NO_Inst/ZeroWord).
  localparam logic [PIPE_STAGE_W-1:0] PIPE_RST_DATA = '0;

  // Skid-mode control states; the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage : id_alu_pipe_stage_pkg
`default_nettype wire

// File: rtl/id_alu_pipe_stage_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_slot                                                        |
// | Purpose : One valid+data register with clear/load/unload enables.          |
// | Ports   : clk, rst      - clock, synchronous active-high reset             |
// |           clr_i         - invalidate and restore RST_DATA (wins over load)  |
// |           load_i,data_i - capture data_i and set valid                     |
// |           unload_i      - drop valid, keep data                            |
// |           valid_o,data_o- registered slot contents                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_slot #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/id_alu_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : id_alu_pipe_stage                                                |
// | Purpose : Valid/ready register slice between decoder and ALU with flush,   |
// |           optional 2-entry skid buffer and saturating stall counter.       |
// | Ports   : clk, rst_n (synchronous, active-high)                            |
// |           flush                   - drop all held entries at next edge     |
// |           in_valid/in_ready/in_data    - upstream handshake               |
// |           out_valid/out_ready/out_data - downstream handshake             |
// |           occupancy               - entries held (0..2)                   |
// |           stall_cnt               - saturating count of stalled cycles    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module id_alu_pipe_stage
  import id_alu_pipe_stage_pkg::*;
#(
  parameter int                DATA_W   = PIPE_STAGE_W,
  parameter int                SKID     = 0,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  generate
    if (SKID == 0) begin : g_single
      logic main_valid;
      logic main_load;
      logic main_unload;

      // Ready looks through to out_ready so a pop and a push share one edge.
      assign in_ready    = !main_valid || out_ready;
      assign main_load   = in_valid && in_ready && !flush;
      assign main_unload = main_valid && out_ready;

      pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
        .clk      (clk),
        .rst      (rst_n),
        .clr_i    (flush),
        .load_i   (main_load),
        .unload_i (main_unload),
        .data_i   (in_data),
        .valid_o  (main_valid),
        .data_o   (out_data)
      );

      assign out_valid = main_valid;
      assign occupancy = {1'b0, main_valid};
    end else begin : g_skid
      skid_state_e       state_q, state_d;
      logic              ready_q;
      logic              main_valid, skid_valid;
      logic [DATA_W-1:0] skid_data, main_din;
      logic              main_load, main_unload, main_sel_skid;
      logic              skid_load, skid_unload;
      logic              in_xfer, out_xfer;

      assign in_xfer  = in_valid && ready_q;
      assign out_xfer = main_valid && out_ready;

      always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_unload   = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                main_load = 1'b1;
                state_d   = ST_ONE;
              end
            end
            ST_ONE: begin
              if (in_xfer && out_xfer) begin
                main_load = 1'b1;
              end else if (in_xfer) begin
                skid_load = 1'b1;
                state_d   = ST_FULL;
              end else if (out_xfer) begin
                main_unload = 1'b1;
                state_d     = ST_EMPTY;
              end
            end
            ST_FULL: begin
              // ready_q is low here, so only the skid-to-main move can happen.
              if (out_xfer) begin
                main_load     = 1'b1;
                main_sel_skid = 1'b1;
                skid_unload   = 1'b1;
                state_d       = ST_ONE;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          // Registered ready breaks the out_ready -> in_ready path.
          ready_q <= (state_d != ST_FULL);
        end
      end

      assign main_din = main_sel_skid ? skid_data : in_data;

      pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
        .clk      (clk),
        .rst      (rst_n),
        .clr_i    (flush),
        .load_i   (main_load),
        .unload_i (main_unload),
        .data_i   (main_din),
        .valid_o  (main_valid),
        .data_o   (out_data)
      );

      pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
        .clk      (clk),
        .rst      (rst_n),
        .clr_i    (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (in_data),
        .valid_o  (skid_valid),
        .data_o   (skid_data)
      );

      assign in_ready  = ready_q;
      assign out_valid = main_valid;
      // The skid slot is only ever valid behind a valid main slot.
      assign occupancy = {skid_valid, main_valid && !skid_valid};
    end
  endgenerate

  // Stall counter: saturates at all-ones, flushed cycles are not counted.
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule : id_alu_pipe_stage
`default_nettype wire

// File: tb/tb_id_alu_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_id_alu_pipe_stage                                             |
// | Purpose : Self-checking bench: three stage instances (single slot, skid,   |
// |           skid with 4-bit counter and non-zero reset payload) share one    |
// |           stimulus; directed scenarios plus a randomized run against a     |
// |           FIFO-style reference model.                                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_id_alu_pipe_stage;

  localparam int DW = 177;
  localparam logic [DW-1:0] RST2 = 177'h1_5A5A_C3C3;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic [2:0]    ir, ov;
  logic [DW-1:0] od [3];
  logic [1:0]    occ [3];
  logic [31:0]   sc0, sc1;
  logic [3:0]    sc2;

  int total = 0;
  int bad   = 0;

  // Reference model: each stage is a FIFO of at most 2 entries.
  logic [DW-1:0] mdata [3][2];
  int            mcnt  [3];
  longint        mstall[3];
  bit            mclean[3];

  always #5 clk = ~clk;

  id_alu_pipe_stage #(.DATA_W(DW), .SKID(0), .RST_DATA('0), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occ[0]), .stall_cnt(sc0));

  id_alu_pipe_stage #(.DATA_W(DW), .SKID(1), .RST_DATA('0), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occ[1]), .stall_cnt(sc1));

  id_alu_pipe_stage #(.DATA_W(DW), .SKID(1), .RST_DATA(RST2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occ[2]), .stall_cnt(sc2));

  function automatic logic [DW-1:0] rst_val(input int d);
    return (d == 2) ? RST2 : '0;
  endfunction

  function automatic longint stall_of(input int d);
    if (d == 0) return longint'(sc0);
    if (d == 1) return longint'(sc1);
    return longint'(sc2);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit     rdy, pop, push;
      longint smax;
      smax = (d == 2) ? 15 : 64'hFFFF_FFFF;
      rdy  = (d == 0) ? (mcnt[d] == 0 || out_ready) : (mcnt[d] < 2);
      if (rst_n) begin
        mcnt[d] = 0; mstall[d] = 0; mclean[d] = 1'b1;
      end else if (flush) begin
        mcnt[d] = 0; mclean[d] = 1'b1;
      end else begin
        if (mcnt[d] > 0 && !out_ready && mstall[d] < smax) mstall[d]++;
        pop  = (mcnt[d] > 0) && out_ready;
        push = in_valid && rdy;
        if (pop) begin
          mdata[d][0] = mdata[d][1];
          mcnt[d]--;
        end
        if (push) begin
          mdata[d][mcnt[d]] = in_data;
          mcnt[d]++;
          mclean[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = rand_data();
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (ov[d] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got %b want 0", d, ov[d]); end
      total++;
      if (od[d] !== rst_val(d)) begin bad++; $display("FAIL reset_data dut%0d got %h want %h", d, od[d], rst_val(d)); end
      total++;
      if (occ[d] !== 2'd0) begin bad++; $display("FAIL reset_occ dut%0d got %0d want 0", d, occ[d]); end
      total++;
      if (stall_of(d) != 0) begin bad++; $display("FAIL reset_stall dut%0d got %0d want 0", d, stall_of(d)); end
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (ir[d] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d got %b want 1", d, ir[d]); end
    end
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      #1;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (ir[d] !== 1'b1) begin bad++; $display("FAIL stream_ready dut%0d beat%0d got %b want 1", d, i, ir[d]); end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (ov[d] !== 1'b1 || od[d] !== DW'(i)) begin
          bad++; $display("FAIL stream_data dut%0d beat%0d got v=%b %h want v=1 %h", d, i, ov[d], od[d], DW'(i));
        end
      end
    end
    in_valid = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (ov[d] !== 1'b0) begin bad++; $display("FAIL stream_drain dut%0d got %b want 0", d, ov[d]); end
      total++;
      if (stall_of(d) != 0) begin bad++; $display("FAIL stream_stall dut%0d got %0d want 0", d, stall_of(d)); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = rand_data(); b = rand_data(); c = rand_data();
    out_ready = 1'b0; in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    #1;
    total++;
    if (ir[1] !== 1'b1) begin bad++; $display("FAIL bp_ready_one got %b want 1", ir[1]); end
    tick();
    in_data = c;
    repeat (3) tick();
    for (int d = 1; d < 3; d++) begin
      total++;
      if (occ[d] !== 2'd2) begin bad++; $display("FAIL bp_occ dut%0d got %0d want 2", d, occ[d]); end
      total++;
      if (ir[d] !== 1'b0) begin bad++; $display("FAIL bp_ready_full dut%0d got %b want 0", d, ir[d]); end
      total++;
      if (ov[d] !== 1'b1 || od[d] !== a) begin bad++; $display("FAIL bp_hold dut%0d got v=%b %h want v=1 %h", d, ov[d], od[d], a); end
      total++;
      if (stall_of(d) != 4) begin bad++; $display("FAIL bp_stall dut%0d got %0d want 4", d, stall_of(d)); end
    end
    out_ready = 1'b1;
    tick();
    for (int d = 1; d < 3; d++) begin
      total++;
      if (od[d] !== b || occ[d] !== 2'd1) begin bad++; $display("FAIL bp_second dut%0d got %h occ=%0d want %h occ=1", d, od[d], occ[d], b); end
    end
    tick();
    in_valid = 1'b0;
    for (int d = 1; d < 3; d++) begin
      total++;
      if (od[d] !== c || ov[d] !== 1'b1) begin bad++; $display("FAIL bp_third dut%0d got v=%b %h want v=1 %h", d, ov[d], od[d], c); end
    end
    tick();
    for (int d = 1; d < 3; d++) begin
      total++;
      if (ov[d] !== 1'b0) begin bad++; $display("FAIL bp_empty dut%0d got %b want 0", d, ov[d]); end
      total++;
      if (stall_of(d) != 4) begin bad++; $display("FAIL bp_stall_end dut%0d got %0d want 4", d, stall_of(d)); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] dd;
    dd = rand_data();
    out_ready = 1'b0; in_valid = 1'b1; in_data = rand_data();
    tick();
    in_data = rand_data();
    tick();
    total++;
    if (occ[1] !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got %0d want 2", occ[1]); end
    flush = 1'b1; in_data = dd;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (ov[d] !== 1'b0 || occ[d] !== 2'd0) begin bad++; $display("FAIL flush_clear dut%0d got v=%b occ=%0d want v=0 occ=0", d, ov[d], occ[d]); end
      total++;
      if (od[d] !== rst_val(d)) begin bad++; $display("FAIL flush_data dut%0d got %h want %h", d, od[d], rst_val(d)); end
      total++;
      if (ir[d] !== 1'b1) begin bad++; $display("FAIL flush_ready dut%0d got %b want 1", d, ir[d]); end
    end
    for (int d = 1; d < 3; d++) begin
      total++;
      if (stall_of(d) != 5) begin bad++; $display("FAIL flush_stall dut%0d got %0d want 5", d, stall_of(d)); end
    end
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (ov[d] !== 1'b0) begin bad++; $display("FAIL flush_ghost dut%0d got v=%b %h want v=0", d, ov[d], od[d]); end
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; in_valid = 1'b1; in_data = rand_data();
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    total++;
    if (sc2 !== 4'd15) begin bad++; $display("FAIL sat_reach got %0d want 15", sc2); end
    total++;
    if (sc1 !== 32'd25) begin bad++; $display("FAIL sat_wide got %0d want 25", sc1); end
    repeat (3) tick();
    total++;
    if (sc2 !== 4'd15) begin bad++; $display("FAIL sat_hold got %0d want 15", sc2); end
    total++;
    if (sc1 !== 32'd28) begin bad++; $display("FAIL sat_wide_more got %0d want 28", sc1); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit            hold [3];
    logic [DW-1:0] prev [3];
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_edge();
    tick();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) hold[d] = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      rst_n     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rand_data();
      #1;
      for (int d = 0; d < 3; d++) begin
        bit exp_rdy;
        exp_rdy = (d == 0) ? (mcnt[d] == 0 || out_ready) : (mcnt[d] < 2);
        total++;
        if (ov[d] !== (mcnt[d] > 0) || occ[d] !== 2'(mcnt[d])) begin
          bad++; $display("FAIL rnd_state dut%0d cyc%0d got v=%b occ=%0d want occ=%0d", d, n, ov[d], occ[d], mcnt[d]);
        end
        total++;
        if (ir[d] !== exp_rdy) begin bad++; $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", d, n, ir[d], exp_rdy); end
        if (mcnt[d] > 0) begin
          total++;
          if (od[d] !== mdata[d][0]) begin bad++; $display("FAIL rnd_data dut%0d cyc%0d got %h want %h", d, n, od[d], mdata[d][0]); end
        end else if (mclean[d]) begin
          total++;
          if (od[d] !== rst_val(d)) begin bad++; $display("FAIL rnd_rstdata dut%0d cyc%0d got %h want %h", d, n, od[d], rst_val(d)); end
        end
        total++;
        if (stall_of(d) != mstall[d]) begin bad++; $display("FAIL rnd_stall dut%0d cyc%0d got %0d want %0d", d, n, stall_of(d), mstall[d]); end
        if (hold[d]) begin
          total++;
          if (ov[d] !== 1'b1 || od[d] !== prev[d]) begin
            bad++; $display("FAIL rnd_hold dut%0d cyc%0d got v=%b %h want v=1 %h", d, n, ov[d], od[d], prev[d]);
          end
        end
        hold[d] = ov[d] && !out_ready && !flush && !rst_n;
        prev[d] = od[d];
      end
      model_edge();
      tick();
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_alu_pipe_stage
`default_nettype wire
